// File: rtl/mouse_packet_decoder_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM encoding,
// status-byte bit positions, datapath widths and default geometry.
package mouse_pkg;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2,
      UPDATE  = 2'd3
   } state_t;

   localparam int BIT_LEFT  = 0;
   localparam int BIT_RIGHT = 1;
   localparam int BIT_SYNC  = 3;
   localparam int BIT_XSIGN = 4;
   localparam int BIT_YSIGN = 5;
   localparam int BIT_XOVF  = 6;
   localparam int BIT_YOVF  = 7;

   localparam int BYTE_W  = 8;
   localparam int ERR_W   = 2;
   localparam int POS_W   = 8;
   localparam int DELTA_W = 9;
   localparam int STEP_W  = 10;

   localparam int DEF_MAX_X   = 160;
   localparam int DEF_MAX_Y   = 120;
   localparam int DEF_TIMEOUT = 100000;

   // An overflowed axis carries no usable movement, so it contributes zero.
   function automatic logic signed [DELTA_W-1:0] axis_delta(input logic sign,
                                                            input logic ovf,
                                                            input logic [BYTE_W-1:0] mag);
      if (ovf) return '0;
      return $signed({sign, mag});
   endfunction

endpackage

// File: rtl/mouse_packet_decoder_if.sv
// Byte-receiver side and decoded-packet side of the mouse decoder.
interface mouse_packet_decoder_if;
   import mouse_pkg::*;

   logic                 ENABLE;
   logic                 READ_ENABLE;
   logic [BYTE_W-1:0]    BYTE_READ;
   logic [ERR_W-1:0]     BYTE_ERROR_CODE;
   logic                 BYTE_READY;
   logic [POS_W-1:0]     MOUSE_X;
   logic [POS_W-1:0]     MOUSE_Y;
   logic [BYTE_W-1:0]    MOUSE_STATUS;
   logic [DELTA_W-1:0]   MOUSE_DX;
   logic [DELTA_W-1:0]   MOUSE_DY;
   logic                 PACKET_VALID;
   logic                 PACKET_ERROR;

   modport master (
      output ENABLE, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
      input  READ_ENABLE, MOUSE_X, MOUSE_Y, MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
             PACKET_VALID, PACKET_ERROR
   );

   modport slave (
      input  ENABLE, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
      output READ_ENABLE, MOUSE_X, MOUSE_Y, MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
             PACKET_VALID, PACKET_ERROR
   );

endinterface

// File: rtl/mouse_packet_decoder_clamp.sv
// One axis of position tracking: position plus signed step, saturated
// to the inclusive range 0..limit.
module mouse_axis_clamp
   import mouse_pkg::*;
(
   input  logic        [POS_W-1:0]  pos,
   input  logic signed [STEP_W-1:0] step,
   input  logic        [POS_W-1:0]  limit,
   output logic        [POS_W-1:0]  pos_next
);

   localparam int ACC_W = STEP_W + 1;

   function automatic logic [POS_W-1:0] sat_pos(input logic signed [ACC_W-1:0] v,
                                                input logic [POS_W-1:0] lim);
      if (v < 0) return '0;
      if (v > $signed({{(ACC_W-POS_W){1'b0}}, lim})) return lim;
      return v[POS_W-1:0];
   endfunction

   logic signed [ACC_W-1:0] sum_p0;

   assign sum_p0   = $signed({{(ACC_W-POS_W){1'b0}}, pos})
                   + $signed({step[STEP_W-1], step});
   assign pos_next = sat_pos(sum_p0, limit);

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets, tracks a clamped screen position and
// reports good/discarded packets as single-cycle pulses.
module mouse_packet_decoder
   import mouse_pkg::*;
#(
   parameter int MAX_X   = DEF_MAX_X,
   parameter int MAX_Y   = DEF_MAX_Y,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   CLK,
   input  logic                   RESET,
   mouse_packet_decoder_if.slave  bus
);

   localparam int              CNT_W  = $clog2(TIMEOUT + 1);
   localparam logic [POS_W-1:0] X_LIM = POS_W'(MAX_X - 1);
   localparam logic [POS_W-1:0] Y_LIM = POS_W'(MAX_Y - 1);
   localparam logic [POS_W-1:0] X_MID = POS_W'(MAX_X / 2);
   localparam logic [POS_W-1:0] Y_MID = POS_W'(MAX_Y / 2);

   state_t                     state;
   logic        [CNT_W-1:0]    idle_cnt;
   logic        [BYTE_W-1:0]   status_p0, byte1_p0, byte2_p0;
   logic signed [DELTA_W-1:0]  dx_p0, dy_p0;
   logic signed [STEP_W-1:0]   step_x_p0, step_y_p0;
   logic        [POS_W-1:0]    x_next_p0, y_next_p0;
   logic                       vld_p0, err_p0;
   logic        [POS_W-1:0]    x_p1, y_p1;
   logic        [BYTE_W-1:0]   status_p1;
   logic signed [DELTA_W-1:0]  dx_p1, dy_p1;
   logic                       vld_p1, err_p1, read_en;
   logic                       byte_ok, byte_bad, idle_expired;

   assign byte_ok      = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == '0);
   assign byte_bad     = bus.BYTE_READY && (bus.BYTE_ERROR_CODE != '0);
   assign idle_expired = (idle_cnt == CNT_W'(TIMEOUT - 1));

   // Stage p0: captured packet bytes and the UPDATE-cycle position arithmetic.
   always_ff @(posedge CLK) begin
      if (bus.ENABLE && byte_ok) begin
         case (state)
            WAIT_B0: if (bus.BYTE_READ[BIT_SYNC]) status_p0 <= bus.BYTE_READ;
            WAIT_B1: byte1_p0 <= bus.BYTE_READ;
            WAIT_B2: byte2_p0 <= bus.BYTE_READ;
            default: ;
         endcase
      end
   end

   assign dx_p0     = axis_delta(status_p0[BIT_XSIGN], status_p0[BIT_XOVF], byte1_p0);
   assign dy_p0     = axis_delta(status_p0[BIT_YSIGN], status_p0[BIT_YOVF], byte2_p0);
   assign step_x_p0 = $signed({dx_p0[DELTA_W-1], dx_p0});
   // Screen Y grows downward while mouse dy grows upward.
   assign step_y_p0 = -$signed({dy_p0[DELTA_W-1], dy_p0});

   mouse_axis_clamp clamp_x (.pos(x_p1), .step(step_x_p0), .limit(X_LIM), .pos_next(x_next_p0));
   mouse_axis_clamp clamp_y (.pos(y_p1), .step(step_y_p0), .limit(Y_LIM), .pos_next(y_next_p0));

   // Stage p1: FSM, registered outputs; pulses leave one cycle after being flagged.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= WAIT_B0;
         idle_cnt  <= '0;
         vld_p0    <= 1'b0;
         err_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         err_p1    <= 1'b0;
         read_en   <= 1'b0;
         x_p1      <= X_MID;
         y_p1      <= Y_MID;
         status_p1 <= '0;
         dx_p1     <= '0;
         dy_p1     <= '0;
      end else begin
         read_en <= bus.ENABLE;
         vld_p1  <= vld_p0;
         err_p1  <= err_p0;
         vld_p0  <= 1'b0;
         err_p0  <= 1'b0;
         if (!bus.ENABLE) begin
            state    <= WAIT_B0;
            idle_cnt <= '0;
         end else begin
            case (state)
               WAIT_B0: begin
                  idle_cnt <= '0;
                  if (byte_bad) err_p0 <= 1'b1;
                  else if (byte_ok && bus.BYTE_READ[BIT_SYNC]) state <= WAIT_B1;
               end
               WAIT_B1, WAIT_B2: begin
                  if (bus.BYTE_READY) begin
                     idle_cnt <= '0;
                     if (byte_bad) begin
                        err_p0 <= 1'b1;
                        state  <= WAIT_B0;
                     end else begin
                        state <= (state == WAIT_B1) ? WAIT_B2 : UPDATE;
                     end
                  end else if (idle_expired) begin
                     idle_cnt <= '0;
                     err_p0   <= 1'b1;
                     state    <= WAIT_B0;
                  end else begin
                     idle_cnt <= idle_cnt + CNT_W'(1);
                  end
               end
               UPDATE: begin
                  x_p1      <= x_next_p0;
                  y_p1      <= y_next_p0;
                  status_p1 <= status_p0;
                  dx_p1     <= dx_p0;
                  dy_p1     <= dy_p0;
                  vld_p0    <= 1'b1;
                  idle_cnt  <= '0;
                  state     <= WAIT_B0;
               end
               default: state <= WAIT_B0;
            endcase
         end
      end
   end

   assign bus.READ_ENABLE  = read_en;
   assign bus.MOUSE_X      = x_p1;
   assign bus.MOUSE_Y      = y_p1;
   assign bus.MOUSE_STATUS = status_p1;
   assign bus.MOUSE_DX     = dx_p1;
   assign bus.MOUSE_DY     = dy_p1;
   assign bus.PACKET_VALID = vld_p1;
   assign bus.PACKET_ERROR = err_p1;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed and randomized byte streams against a packet-level model of the
// mouse decoder: position clamping, resync, error/timeout and pulse timing.
module tb_mouse_packet_decoder;

   localparam int MX = 160;
   localparam int MY = 120;
   localparam int TO = 40;

   logic CLK = 1'b0;
   logic RESET = 1'b0;

   mouse_packet_decoder_if bus();

   mouse_packet_decoder #(.MAX_X(MX), .MAX_Y(MY), .TIMEOUT(TO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Packet-level reference state
   int         exp_x, exp_y, exp_status, exp_dx, exp_dy;
   int         got;
   logic [7:0] pkt [3];
   int         exp_valids = 0;
   int         exp_errs   = 0;

   int seen_valids = 0;
   int seen_errs   = 0;
   int overlap     = 0;

   always @(negedge CLK) begin
      if (RESET) begin
         if (bus.PACKET_VALID === 1'b1) seen_valids++;
         if (bus.PACKET_ERROR === 1'b1) seen_errs++;
         if (bus.PACKET_VALID === 1'b1 && bus.PACKET_ERROR === 1'b1) overlap++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int mdelta(input bit sign, input bit ovf, input logic [7:0] b);
      if (ovf) return 0;
      return sign ? int'(b) - 256 : int'(b);
   endfunction

   task automatic model_reset();
      exp_x = MX / 2;  exp_y = MY / 2;
      exp_status = 0;  exp_dx = 0;  exp_dy = 0;
      got = 0;
   endtask

   // Returns 0 = nothing observable, 1 = error pulse expected, 2 = packet applied.
   task automatic model_byte(input logic [7:0] b, input logic [1:0] code, output int ev);
      int dx, dy;
      ev = 0;
      if (code != 2'b00) begin
         got = 0;
         ev  = 1;
      end else if (got == 0 && b[3] == 1'b0) begin
         ev = 0;
      end else begin
         pkt[got] = b;
         got++;
         if (got == 3) begin
            dx = mdelta(pkt[0][4], pkt[0][6], pkt[1]);
            dy = mdelta(pkt[0][5], pkt[0][7], pkt[2]);
            exp_x      = clampi(exp_x + dx, MX - 1);
            exp_y      = clampi(exp_y - dy, MY - 1);
            exp_status = int'(pkt[0]);
            exp_dx     = dx & 'h1FF;
            exp_dy     = dy & 'h1FF;
            got = 0;
            ev  = 2;
         end
      end
   endtask

   task automatic drive(input logic [7:0] b, input logic [1:0] code);
      @(negedge CLK);
      bus.BYTE_READ       = b;
      bus.BYTE_ERROR_CODE = code;
      bus.BYTE_READY      = 1'b1;
      @(negedge CLK);
      bus.BYTE_READY      = 1'b0;
      bus.BYTE_ERROR_CODE = 2'b00;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_x"},      32'(bus.MOUSE_X),      32'(exp_x));
      chk({tag, "_y"},      32'(bus.MOUSE_Y),      32'(exp_y));
      chk({tag, "_status"}, 32'(bus.MOUSE_STATUS), 32'(exp_status));
      chk({tag, "_dx"},     32'(bus.MOUSE_DX),     32'(exp_dx));
      chk({tag, "_dy"},     32'(bus.MOUSE_DY),     32'(exp_dy));
   endtask

   task automatic send(input logic [7:0] b, input logic [1:0] code);
      int ev;
      drive(b, code);
      model_byte(b, code, ev);
      if (ev == 1) begin
         exp_errs++;
         @(posedge CLK); #1;
         chk("err_pulse", 32'(bus.PACKET_ERROR), 32'd1);
      end else if (ev == 2) begin
         exp_valids++;
         @(posedge CLK); #1;
         chk("valid_early", 32'(bus.PACKET_VALID), 32'd0);
         @(posedge CLK); #1;
         chk("valid_pulse", 32'(bus.PACKET_VALID), 32'd1);
         check_outputs("pkt");
      end
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send(b0, 2'b00);
      send(b1, 2'b00);
      send(b2, 2'b00);
   endtask

   initial begin
      logic [7:0] rb;
      logic [1:0] rc;
      int         errs_before;
      int         x_before;

      bus.ENABLE = 1'b1;
      bus.BYTE_READ = '0;
      bus.BYTE_ERROR_CODE = '0;
      bus.BYTE_READY = 1'b0;
      model_reset();

      repeat (3) @(negedge CLK);
      chk("rst_x",     32'(bus.MOUSE_X),      32'd80);
      chk("rst_y",     32'(bus.MOUSE_Y),      32'd60);
      chk("rst_status",32'(bus.MOUSE_STATUS), 32'd0);
      chk("rst_dx",    32'(bus.MOUSE_DX),     32'd0);
      chk("rst_dy",    32'(bus.MOUSE_DY),     32'd0);
      chk("rst_valid", 32'(bus.PACKET_VALID), 32'd0);
      chk("rst_error", 32'(bus.PACKET_ERROR), 32'd0);
      chk("rst_rden",  32'(bus.READ_ENABLE),  32'd0);
      RESET = 1'b1;
      @(posedge CLK); #1;
      chk("rden_on", 32'(bus.READ_ENABLE), 32'd1);

      // Basic packet from centre
      send_pkt(8'h08, 8'h05, 8'h03);
      chk("basic_x", 32'(bus.MOUSE_X), 32'd85);
      chk("basic_y", 32'(bus.MOUSE_Y), 32'd57);
      @(posedge CLK); #1;
      chk("valid_one_cycle", 32'(bus.PACKET_VALID), 32'd0);

      // Negative X and right-edge saturation
      send_pkt(8'h18, 8'hFB, 8'h00);
      send_pkt(8'h18, 8'hF6, 8'h00);
      chk("neg_dx_x", 32'(bus.MOUSE_X), 32'd70);
      for (int i = 0; i < 20; i++) send_pkt(8'h08, 8'hFF, 8'h00);
      chk("x_sat_hi", 32'(bus.MOUSE_X), 32'd159);

      // Y bottom and top clamping
      send_pkt(8'h28, 8'h00, 8'hFD);
      chk("y_back_60", 32'(bus.MOUSE_Y), 32'd60);
      send_pkt(8'h28, 8'h00, 8'h80);
      chk("y_sat_hi", 32'(bus.MOUSE_Y), 32'd119);
      send_pkt(8'h08, 8'h00, 8'h7F);
      send_pkt(8'h08, 8'h00, 8'h7F);
      chk("y_sat_lo", 32'(bus.MOUSE_Y), 32'd0);

      // Resync: byte without bit3 dropped silently
      errs_before = seen_errs;
      send(8'h01, 2'b00);
      send_pkt(8'h08, 8'h02, 8'h02);
      chk("resync_no_err", 32'(seen_errs), 32'(errs_before));

      // Byte error mid-packet
      x_before = int'(bus.MOUSE_X);
      send(8'h08, 2'b00);
      send(8'h05, 2'b01);
      chk("err_x_kept", 32'(bus.MOUSE_X), 32'(x_before));

      // Inter-byte timeout
      send(8'h08, 2'b00);
      repeat (TO) @(posedge CLK);
      #1 chk("timeout_not_yet", 32'(bus.PACKET_ERROR), 32'd0);
      @(posedge CLK); #1;
      chk("timeout_err", 32'(bus.PACKET_ERROR), 32'd1);
      got = 0;
      exp_errs++;
      send_pkt(8'h08, 8'h01, 8'h01);

      // X overflow forces dx to zero
      x_before = int'(bus.MOUSE_X);
      send_pkt(8'h48, 8'hFF, 8'h00);
      chk("ovf_x_kept", 32'(bus.MOUSE_X), 32'(x_before));
      chk("ovf_dx_zero", 32'(bus.MOUSE_DX), 32'd0);

      // Reset mid-packet
      send(8'h08, 2'b00);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      model_reset();
      chk("midrst_x", 32'(bus.MOUSE_X), 32'd80);
      chk("midrst_y", 32'(bus.MOUSE_Y), 32'd60);
      @(negedge CLK);
      RESET = 1'b1;
      send_pkt(8'h08, 8'h01, 8'h01);
      chk("post_rst_x", 32'(bus.MOUSE_X), 32'd81);
      chk("post_rst_y", 32'(bus.MOUSE_Y), 32'd59);

      // ENABLE low drops a partial packet without an error
      send(8'h08, 2'b00);
      send(8'h05, 2'b00);
      @(negedge CLK);
      bus.ENABLE = 1'b0;
      @(posedge CLK); #1;
      chk("rden_off", 32'(bus.READ_ENABLE), 32'd0);
      @(negedge CLK);
      bus.ENABLE = 1'b1;
      got = 0;
      send_pkt(8'h08, 8'h03, 8'h04);

      // Randomized byte stream with occasional receiver errors
      for (int i = 0; i < 300; i++) begin
         rb = 8'($urandom);
         rc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (got == 0 && $urandom_range(0, 3) != 0) rb[3] = 1'b1;
         send(rb, rc);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge CLK);
      end
      check_outputs("final");

      repeat (4) @(negedge CLK);
      chk("valid_count", 32'(seen_valids), 32'(exp_valids));
      chk("error_count", 32'(seen_errs),   32'(exp_errs));
      chk("no_overlap",  32'(overlap),     32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
